// File: rtl/oled_render_pkg.sv
// Shared colour constants, shape codes and input sanitising helpers for the OLED
// border/shape renderer. Optional feature macro: SHAPE_BLINK_EN.
package oled_render_pkg;

  localparam logic [15:0] ORANGE = 16'hFC00;
  localparam logic [15:0] GREEN  = 16'h07E0;
  localparam logic [15:0] RED    = 16'hF800;
  localparam logic [15:0] BLUE   = 16'h001F;
  localparam logic [15:0] YELLOW = 16'hFFE0;
  localparam logic [15:0] BLACK  = 16'h0000;

  // Coordinate / distance width; wide enough for any row a 13-bit index can produce.
  localparam int CW = 8;

  typedef enum logic [1:0] {
    SHAPE_NONE    = 2'd0,
    SHAPE_SQUARE  = 2'd1,
    SHAPE_DIAMOND = 2'd2,
    SHAPE_PLUS    = 2'd3
  } shape_e;

  // Values 4..7 on the 3-bit shape/stage inputs collapse to 0.
  function automatic logic [1:0] clip3(input logic [2:0] v);
    return v[2] ? 2'd0 : v[1:0];
  endfunction

endpackage

// File: rtl/oled_pixel_coord.sv
// S1 stage: pixel_index -> registered col/row, edge distance d, and |col-CX|, |row-CY|.
module oled_pixel_coord
  import oled_render_pkg::*;
#(
  parameter int WIDTH  = 96,
  parameter int HEIGHT = 64,
  parameter int CX     = 48,
  parameter int CY     = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [12:0]   pixel_index_i,
  output logic [CW-1:0] col_o,
  output logic [CW-1:0] row_o,
  output logic [CW-1:0] d_o,
  output logic [CW-1:0] dx_o,
  output logic [CW-1:0] dy_o,
  output logic          valid_o
);

  logic [12:0]   col_full, row_full;
  logic [CW-1:0] col_c, row_c, right_c, bottom_c, dh_c, dv_c;
  logic [CW-1:0] d_d, dx_d, dy_d;
  logic          valid_d;

  // Split the row-major index and derive distances; out-of-range indices are flagged invalid
  always_comb begin
    col_full = pixel_index_i % 13'(WIDTH);
    row_full = pixel_index_i / 13'(WIDTH);
    col_c    = col_full[CW-1:0];
    row_c    = row_full[CW-1:0];
    valid_d  = (pixel_index_i < 13'(WIDTH * HEIGHT));
    right_c  = CW'(WIDTH - 1) - col_c;
    bottom_c = CW'(HEIGHT - 1) - row_c;
    dh_c     = (col_c < right_c) ? col_c : right_c;
    dv_c     = (row_c < bottom_c) ? row_c : bottom_c;
    d_d      = (dh_c < dv_c) ? dh_c : dv_c;
    dx_d     = (col_c >= CW'(CX)) ? (col_c - CW'(CX)) : (CW'(CX) - col_c);
    dy_d     = (row_c >= CW'(CY)) ? (row_c - CW'(CY)) : (CW'(CY) - row_c);
  end

  // S1 pipeline register
  always_ff @(posedge clk) begin
    if (reset) begin
      col_o   <= '0;
      row_o   <= '0;
      d_o     <= '0;
      dx_o    <= '0;
      dy_o    <= '0;
      valid_o <= 1'b0;
    end else begin
      col_o   <= col_c;
      row_o   <= row_c;
      d_o     <= d_d;
      dx_o    <= dx_d;
      dy_o    <= dy_d;
      valid_o <= valid_d;
    end
  end

endmodule

// File: rtl/oled_border_shape_renderer.sv
// OLED border/shape renderer: orange frame, staged green rings and a centre shape,
// with frame-aligned state latching and a req/ack shape-select handshake.
// Optional feature macro: SHAPE_BLINK_EN (shape pixels blink on frame_cnt[BLINK_SHIFT]).
module oled_border_shape_renderer
  import oled_render_pkg::*;
#(
  parameter int WIDTH       = 96,
  parameter int HEIGHT      = 64,
  parameter int CX          = 48,
  parameter int CY          = 32,
  parameter int BLINK_SHIFT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [12:0] pixel_index,
  input  logic        frame_begin,
  input  logic        orange_en,
  input  logic [2:0]  border_stage,
  input  logic        shape_req,
  input  logic [2:0]  shape_in,
  output logic        shape_ack,
  output logic [15:0] pixel_data
);

  typedef enum logic {HS_ARMED, HS_WAIT_LOW} hs_e;

  hs_e           hs_q, hs_d;
  logic          ack_q, ack_d;
  shape_e        pending_q, pending_d;
  shape_e        shape_q;
  logic [1:0]    stage_q;
  logic          orange_q;
  logic [15:0]   pix_q, pix_d;

  logic [CW-1:0] col_s1, row_s1, d_s1, dx_s1, dy_s1;
  logic          valid_s1;
  logic [CW:0]   manhattan;
  logic          green_hit, shape_hit, shape_blank;
  logic [15:0]   shape_colour;

  oled_pixel_coord #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .CX     (CX),
    .CY     (CY)
  ) u_coord (
    .clk           (clk),
    .reset         (reset),
    .pixel_index_i (pixel_index),
    .col_o         (col_s1),
    .row_o         (row_s1),
    .d_o           (d_s1),
    .dx_o          (dx_s1),
    .dy_o          (dy_s1),
    .valid_o       (valid_s1)
  );

  // Handshake FSM register: pending shape and one-cycle ack
  always_ff @(posedge clk) begin
    if (reset) begin
      hs_q      <= HS_ARMED;
      ack_q     <= 1'b0;
      pending_q <= SHAPE_NONE;
    end else begin
      hs_q      <= hs_d;
      ack_q     <= ack_d;
      pending_q <= pending_d;
    end
  end

  // Handshake next state: capture once per request, re-arm after req is seen low
  always_comb begin
    hs_d      = hs_q;
    ack_d     = 1'b0;
    pending_d = pending_q;
    unique case (hs_q)
      HS_ARMED: if (shape_req) begin
        hs_d      = HS_WAIT_LOW;
        ack_d     = 1'b1;
        pending_d = shape_e'(clip3(shape_in));
      end
      HS_WAIT_LOW: if (!shape_req) hs_d = HS_ARMED;
      default: hs_d = HS_ARMED;
    endcase
  end

  // Frame latch: drawing state only changes at frame_begin so a scan never tears
  always_ff @(posedge clk) begin
    if (reset) begin
      orange_q <= 1'b0;
      stage_q  <= '0;
      shape_q  <= SHAPE_NONE;
    end else if (frame_begin) begin
      orange_q <= orange_en;
      stage_q  <= clip3(border_stage);
      shape_q  <= pending_q;
    end
  end

`ifdef SHAPE_BLINK_EN
  logic [7:0] frame_cnt_q;

  // Frame counter driving the shape blink
  always_ff @(posedge clk) begin
    if (reset)            frame_cnt_q <= '0;
    else if (frame_begin) frame_cnt_q <= frame_cnt_q + 8'd1;
  end

  assign shape_blank = frame_cnt_q[BLINK_SHIFT];
`else
  assign shape_blank = 1'b0;
`endif

  // S2 colour selection, first match wins
  always_comb begin
    manhattan    = {1'b0, dx_s1} + {1'b0, dy_s1};
    green_hit    = ((stage_q >= 2'd1) && (d_s1 == CW'(3) || d_s1 == CW'(4))) ||
                   ((stage_q >= 2'd2) && (d_s1 == CW'(6) || d_s1 == CW'(7))) ||
                   ((stage_q == 2'd3) && (d_s1 == CW'(9) || d_s1 == CW'(10)));
    shape_hit    = 1'b0;
    shape_colour = BLACK;
    unique case (shape_q)
      SHAPE_SQUARE: begin
        shape_hit    = (dx_s1 <= CW'(8)) && (dy_s1 <= CW'(8));
        shape_colour = RED;
      end
      SHAPE_DIAMOND: begin
        shape_hit    = (manhattan <= (CW+1)'(10));
        shape_colour = BLUE;
      end
      SHAPE_PLUS: begin
        shape_hit    = ((dx_s1 <= CW'(2)) && (dy_s1 <= CW'(10))) ||
                       ((dy_s1 <= CW'(2)) && (dx_s1 <= CW'(10)));
        shape_colour = YELLOW;
      end
      default: begin
        shape_hit    = 1'b0;
        shape_colour = BLACK;
      end
    endcase

    pix_d = BLACK;
    if (valid_s1 && orange_q) begin
      if (d_s1 == '0)                     pix_d = ORANGE;
      else if (green_hit)                 pix_d = GREEN;
      else if (shape_hit && !shape_blank) pix_d = shape_colour;
    end
  end

  // S2 output register
  always_ff @(posedge clk) begin
    if (reset) pix_q <= BLACK;
    else       pix_q <= pix_d;
  end

  assign shape_ack  = ack_q;
  assign pixel_data = pix_q;

  // col/row are carried in S1 for debug visibility only
  logic unused_coord;
  assign unused_coord = ^{col_s1, row_s1};

endmodule
